fdiv_seq: RTL and testbench

- Sequential single-precision floating-point divider, A / B; the inverse operation of the combinational multiplier in the FPU datapath.
- Operand and result port format matches the multiplier's: split sign/exp/frac fields, 24-bit result frac with the hidden bit explicit.
- Mantissa quotient uses restoring division, one bit per clock, behind a start/busy/done handshake.
- Exception and denormal policy is the FPU's: denormals read as zero, truncation with no rounding.

---
 rtl/fp_pkg.sv | 24 ++
 rtl/frac_div_step.sv | 20 ++
 rtl/fdiv_seq.sv | 177 +++++++++++++++++
 tb/tb_fdiv_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FPU definitions: field widths, exponent constants, the divider's
// state encoding and operand classification helpers. Denormals (exp==0)
// are treated as zero throughout the FPU.
package fp_pkg;
  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [23:0] NAN_FRAC = 24'h800000;
  localparam int          FRAC_W   = 23;
  localparam int          MANT_W   = 24;

  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

  function automatic logic is_zero(input logic [7:0] e);
    return e == 8'd0;
  endfunction

  function automatic logic is_inf(input logic [7:0] e, input logic [FRAC_W-1:0] f);
    return (e == 8'hFF) && (f == '0);
  endfunction

  function automatic logic is_nan(input logic [7:0] e, input logic [FRAC_W-1:0] f);
    return (e == 8'hFF) && (f != '0);
  endfunction
endpackage

// File: rtl/frac_div_step.sv
// One restoring-division step on the mantissa remainder.
//   r      : current partial remainder (26 bits)
//   mb     : divisor mantissa, hidden bit included
//   r_next : remainder for the next step, already shifted left
//   q_bit  : quotient bit produced by this step
module frac_div_step (
  input  logic [25:0] r,
  input  logic [23:0] mb,
  output logic [25:0] r_next,
  output logic        q_bit
);
  logic [25:0] mb_ext;
  logic [25:0] diff;

  assign mb_ext = {2'b00, mb};
  assign q_bit  = (r >= mb_ext);
  assign diff   = q_bit ? (r - mb_ext) : r;
  // The remainder stays below 2*mb, so the shifted-out MSB is always zero.
  assign r_next = diff << 1;
endmodule

// File: rtl/fdiv_seq.sv
// Sequential single-precision divider, A / B.
// Restoring division produces one quotient bit per clock. Denormals read as
// zero, the quotient is truncated. Exceptional operands skip the iteration
// and finish one cycle after start.
//   clk, rst          : clock, async active-high reset
//   start             : request, sampled only in IDLE
//   A_*/B_*           : split sign/exp/frac operands, latched on the start edge
//   busy              : high while the quotient is being computed
//   done              : one-cycle pulse, results valid from this cycle on
//   sign/exp/frac     : registered result, frac[23] is the hidden bit
//   error / overflow  : invalid or divide-by-zero / exponent overflow
module fdiv_seq
  import fp_pkg::*;
#(
  parameter int ITER     = 24,
  parameter int EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        A_sign,
  input  logic [7:0]  A_exp,
  input  logic [22:0] A_frac,
  input  logic        B_sign,
  input  logic [7:0]  B_exp,
  input  logic [22:0] B_frac,
  output logic        busy,
  output logic        done,
  output logic        sign,
  output logic [7:0]  exp,
  output logic [23:0] frac,
  output logic        error,
  output logic        overflow
);
  localparam int CNT_W = $clog2(ITER);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [25:0]        rem;
  logic [23:0]        mb;
  logic [23:0]        q;
  logic signed [9:0]  e;
  logic               sgn_r;

  // Operand classification and exception result, from the live inputs
  logic a_z, a_i, a_n, b_z, b_i, b_n;
  logic exc, exc_err;
  logic [7:0]  exc_exp;
  logic [23:0] exc_frac;

  assign a_z = is_zero(A_exp);
  assign a_i = is_inf(A_exp, A_frac);
  assign a_n = is_nan(A_exp, A_frac);
  assign b_z = is_zero(B_exp);
  assign b_i = is_inf(B_exp, B_frac);
  assign b_n = is_nan(B_exp, B_frac);

  // Ordered by priority: invalid, x/0, inf/x, then the results that are zero.
  always_comb begin
    exc      = 1'b1;
    exc_exp  = 8'hFF;
    exc_frac = 24'd0;
    exc_err  = 1'b0;
    if (a_n || b_n || (a_i && b_i) || (a_z && b_z)) begin
      exc_frac = NAN_FRAC;
      exc_err  = 1'b1;
    end else if (b_z && !a_i) begin
      exc_err  = 1'b1;
    end else if (a_i) begin
      exc_err  = 1'b0;
    end else if (a_z || b_i) begin
      exc_exp  = 8'd0;
    end else begin
      exc      = 1'b0;
    end
  end

  // Pre-normalisation: start with a remainder >= Mb so the first quotient
  // bit is the hidden bit; pay for the extra shift in the exponent.
  logic [23:0] ma_in, mb_in;
  logic        lt;
  logic [25:0] rem_init;
  logic [9:0]  e_init;

  assign ma_in    = {1'b1, A_frac};
  assign mb_in    = {1'b1, B_frac};
  assign lt       = (ma_in < mb_in);
  assign rem_init = lt ? {1'b0, ma_in, 1'b0} : {2'b00, ma_in};
  assign e_init   = 10'(A_exp) - 10'(B_exp) + 10'(EXP_BIAS) - {9'd0, lt};

  logic [25:0] rem_next;
  logic        q_bit;

  frac_div_step u_step (
    .r      (rem),
    .mb     (mb),
    .r_next (rem_next),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = exc ? DONE : CALC;
      CALC: if (cnt == CNT_W'(ITER-1)) state_n = NORM;
      NORM: state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      rem      <= '0;
      mb       <= '0;
      q        <= '0;
      e        <= '0;
      sgn_r    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sign     <= 1'b0;
      exp      <= '0;
      frac     <= '0;
      error    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      busy <= (state_n == CALC) || (state_n == NORM);
      done <= (state_n == DONE);
      case (state)
        IDLE: if (start) begin
          cnt   <= '0;
          q     <= '0;
          rem   <= rem_init;
          mb    <= mb_in;
          e     <= e_init;
          sgn_r <= A_sign ^ B_sign;
          if (exc) begin
            sign     <= A_sign ^ B_sign;
            exp      <= exc_exp;
            frac     <= exc_frac;
            error    <= exc_err;
            overflow <= 1'b0;
          end
        end
        CALC: begin
          rem <= rem_next;
          q   <= {q[22:0], q_bit};
          cnt <= cnt + 1'b1;
        end
        NORM: begin
          sign  <= sgn_r;
          error <= 1'b0;
          if (e >= 10'sd255) begin
            exp      <= 8'hFF;
            frac     <= '0;
            overflow <= 1'b1;
          end else if (e <= 10'sd0) begin
            exp      <= '0;
            frac     <= '0;
            overflow <= 1'b0;
          end else begin
            exp      <= e[7:0];
            frac     <= q;
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fdiv_seq.sv
module tb_fdiv_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        A_sign, B_sign;
  logic [7:0]  A_exp, B_exp;
  logic [22:0] A_frac, B_frac;
  logic        busy, done, sign, error, overflow;
  logic [7:0]  exp;
  logic [23:0] frac;

  int checks = 0;
  int errors = 0;

  fdiv_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .A_sign(A_sign), .A_exp(A_exp), .A_frac(A_frac),
    .B_sign(B_sign), .B_exp(B_exp), .B_frac(B_frac),
    .busy(busy), .done(done), .sign(sign), .exp(exp), .frac(frac),
    .error(error), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference: IEEE-style divide with zero-flushed denormals and truncation.
  task automatic model(input logic as, input logic [7:0] ae, input logic [22:0] af,
                       input logic bs, input logic [7:0] be, input logic [22:0] bf,
                       output logic s, output logic [7:0] e, output logic [23:0] f,
                       output logic err, output logic ov, output int lat);
    bit an, ai, az, bn, bi, bz;
    longint unsigned ma, mb, num, qq;
    int adj, ee;
    an = (ae == 255) && (af != 0);
    ai = (ae == 255) && (af == 0);
    az = (ae == 0);
    bn = (be == 255) && (bf != 0);
    bi = (be == 255) && (bf == 0);
    bz = (be == 0);
    s = as ^ bs; e = 0; f = 0; err = 0; ov = 0; lat = 1;
    if (an || bn || (ai && bi) || (az && bz)) begin
      e = 8'hFF; f = 24'h800000; err = 1;
    end else if (bz && !ai) begin
      e = 8'hFF; err = 1;
    end else if (ai) begin
      e = 8'hFF;
    end else if (az || bi) begin
      e = 0;
    end else begin
      lat = 26;
      ma  = 64'h800000 | longint'(af);
      mb  = 64'h800000 | longint'(bf);
      adj = (ma < mb) ? 1 : 0;
      num = ma << (23 + adj);
      qq  = num / mb;
      ee  = int'(ae) - int'(be) + 127 - adj;
      if (ee >= 255)    begin e = 8'hFF; ov = 1; end
      else if (ee <= 0) begin e = 0; end
      else              begin e = ee[7:0]; f = qq[23:0]; end
    end
  endtask

  task automatic run_op(input string tag,
                        input logic as, input logic [7:0] ae, input logic [22:0] af,
                        input logic bs, input logic [7:0] be, input logic [22:0] bf);
    logic s; logic [7:0] e; logic [23:0] f; logic err, ov; int lat_exp, lat;
    model(as, ae, af, bs, be, bf, s, e, f, err, ov, lat_exp);
    @(negedge clk);
    A_sign = as; A_exp = ae; A_frac = af;
    B_sign = bs; B_exp = be; B_frac = bf;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble operands: the divider must be working from its latched copy.
    A_sign = 1'($urandom); A_exp = 8'($urandom); A_frac = 23'($urandom);
    B_sign = 1'($urandom); B_exp = 8'($urandom); B_frac = 23'($urandom);
    lat = 1;
    while (!done && lat < 60) begin
      if (lat == 5) chk({tag, " busy"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " lat"},   32'(lat),      32'(lat_exp));
    chk({tag, " sign"},  32'(sign),     32'(s));
    chk({tag, " exp"},   32'(exp),      32'(e));
    chk({tag, " frac"},  32'(frac),     32'(f));
    chk({tag, " err"},   32'(error),    32'(err));
    chk({tag, " ovf"},   32'(overflow), 32'(ov));
    @(posedge clk); #1;
    chk({tag, " pulse"}, 32'(done),     32'd0);
    chk({tag, " hold"},  32'(frac),     32'(f));
  endtask

  function automatic logic [7:0] rnd_exp();
    int k = int'($urandom_range(0, 9));
    if (k == 0) return 8'd0;
    if (k == 1) return 8'd255;
    return 8'($urandom_range(1, 254));
  endfunction

  function automatic logic [22:0] rnd_frac();
    if ($urandom_range(0, 3) == 0) return 23'd0;
    return 23'($urandom);
  endfunction

  initial begin
    logic s; logic [7:0] e; logic [23:0] f; logic err, ov; int lat_exp;
    int ndone;
    logic [7:0] got_e; logic [23:0] got_f; logic got_s;

    rst = 1'b1; start = 1'b0;
    A_sign = 0; A_exp = 0; A_frac = 0; B_sign = 0; B_exp = 0; B_frac = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst done", 32'(done), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst exp",  32'(exp),  0);
    chk("rst frac", 32'(frac), 0);
    chk("rst err",  32'(error), 0);
    chk("rst ovf",  32'(overflow), 0);
    @(negedge clk); rst = 1'b0;

    // Directed cases
    run_op("6/2",     0, 8'd129, 23'h400000, 0, 8'd128, 23'h0);
    chk("6/2 frac const", 32'(frac), 32'hC00000);
    run_op("1/3",     0, 8'd127, 23'h0,      0, 8'd128, 23'h400000);
    chk("1/3 frac const", 32'(frac), 32'hAAAAAA);
    run_op("-1/3",    1, 8'd127, 23'h0,      0, 8'd128, 23'h400000);
    run_op("1/0",     0, 8'd127, 23'h0,      0, 8'd0,   23'h0);
    run_op("0/0",     0, 8'd0,   23'h0,      1, 8'd0,   23'h0);
    run_op("inf/2",   0, 8'd255, 23'h0,      0, 8'd128, 23'h0);
    run_op("2/inf",   1, 8'd128, 23'h0,      0, 8'd255, 23'h0);
    run_op("nan/2",   0, 8'd255, 23'h1,      0, 8'd128, 23'h0);
    run_op("inf/inf", 0, 8'd255, 23'h0,      1, 8'd255, 23'h0);
    run_op("inf/0",   0, 8'd255, 23'h0,      0, 8'd0,   23'h0);
    run_op("ovf",     0, 8'd254, 23'h123456, 0, 8'd1,   23'h123456);
    run_op("unf",     0, 8'd1,   23'h123456, 0, 8'd254, 23'h123456);

    // Second start while busy is ignored
    model(0, 8'd130, 23'h2AAAAA, 0, 8'd126, 23'h555555, s, e, f, err, ov, lat_exp);
    @(negedge clk);
    A_sign = 0; A_exp = 8'd130; A_frac = 23'h2AAAAA;
    B_sign = 0; B_exp = 8'd126; B_frac = 23'h555555;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; got_e = 0; got_f = 0; got_s = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin
        A_sign = 1; A_exp = 8'd140; A_frac = 23'h7; B_exp = 8'd100; start = 1'b1;
      end
      if (k == 6) start = 1'b0;
      if (done) begin
        if (ndone == 0) begin got_e = exp; got_f = frac; got_s = sign; end
        ndone++;
      end
    end
    chk("busy-start ndone", 32'(ndone), 32'd1);
    chk("busy-start exp",   32'(got_e), 32'(e));
    chk("busy-start frac",  32'(got_f), 32'(f));
    chk("busy-start sign",  32'(got_s), 32'(s));

    // Reset in the middle of CALC
    run_op("pre-rst", 0, 8'd129, 23'h400000, 0, 8'd128, 23'h0);
    @(negedge clk);
    A_sign = 1; A_exp = 8'd127; A_frac = 23'h0; B_sign = 0; B_exp = 8'd128; B_frac = 23'h400000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst done", 32'(done), 0);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst exp",  32'(exp),  0);
    chk("midrst frac", 32'(frac), 0);
    ndone = 0;
    repeat (20) begin @(posedge clk); #1; if (done) ndone++; end
    @(negedge clk); rst = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (done) ndone++; end
    chk("midrst nodone", 32'(ndone), 0);
    run_op("post-rst", 0, 8'd127, 23'h0, 0, 8'd128, 23'h400000);

    // Randomized operands against the reference
    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rnd%0d", i),
             1'($urandom), rnd_exp(), rnd_frac(),
             1'($urandom), rnd_exp(), rnd_frac());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
